// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and hands words to the decoder.
// Optional MIPS delay-slot behaviour is enabled by defining IFETCH_DELAY_SLOT_EN.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] ins_o,
   output logic        ins_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   input  logic        stall_i,
   input  logic        is_jump_i,
   input  logic        is_jr_i,
   input  logic [25:0] j_addr_i,
   input  logic [31:0] jr_target_i,
   input  logic        is_branch_i,
   input  logic        branch_taken_i,
   input  logic [31:0] ext_immd_i
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] pco_q, pco_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] target_s;
   logic        redirect_s;
`ifdef IFETCH_DELAY_SLOT_EN
   logic        pend_vld_q, pend_vld_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

   // Redirect target for the instruction on ins_o, jr > jump > taken branch
   always_comb begin
      redirect_s = 1'b0;
      target_s   = pc4_q;
      if (is_jr_i) begin
         redirect_s = 1'b1;
         target_s   = {jr_target_i[31:2], 2'b00};
      end else if (is_jump_i) begin
         redirect_s = 1'b1;
         target_s   = {pc4_q[31:28], j_addr_i, 2'b00};
      end else if (is_branch_i && branch_taken_i) begin
         redirect_s = 1'b1;
         target_s   = pc4_q + {ext_immd_i[29:0], 2'b00};
      end else begin
         redirect_s = 1'b0;
         target_s   = pc4_q;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      pco_d   = pco_q;
      pc4_d   = pc4_q;
`ifdef IFETCH_DELAY_SLOT_EN
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
`endif
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ready) begin
               ins_d   = imem_rdata;
               pco_d   = pc_q;
               pc4_d   = pc_q + 32'd4;
               state_d = VALID;
            end else begin
               state_d = FETCH;
            end
         end
         VALID: begin
            if (!stall_i) begin
               state_d = FETCH;
`ifdef IFETCH_DELAY_SLOT_EN
               // A pending target overrides whatever the slot instruction itself requests
               if (pend_vld_q) begin
                  pc_d       = pend_tgt_q;
                  pend_vld_d = 1'b0;
                  pend_tgt_d = 32'h0000_0000;
               end else if (redirect_s) begin
                  pc_d       = pc4_q;
                  pend_vld_d = 1'b1;
                  pend_tgt_d = target_s;
               end else begin
                  pc_d = pc4_q;
               end
`else
               if (redirect_s) begin
                  pc_d = target_s;
               end else begin
                  pc_d = pc4_q;
               end
`endif
            end else begin
               state_d = VALID;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         ins_q   <= 32'h0000_0000;
         pco_q   <= RESET_PC;
         pc4_q   <= RESET_PC + 32'd4;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         pco_q   <= pco_d;
         pc4_q   <= pc4_d;
      end
   end

`ifdef IFETCH_DELAY_SLOT_EN
   // Pending delay-slot target
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld_q <= 1'b0;
         pend_tgt_q <= 32'h0000_0000;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end
`endif

   // Request decodes straight from the state register so reset withdraws it asynchronously
   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign ins_o       = ins_q;
   assign ins_valid_o = (state_q == VALID);
   assign pc_o        = pco_q;
   assign pc_plus4_o  = pc4_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential fetch, wait states, stalls, redirect table, wrap and async reset.
module tb_ifetch;

   logic        sys_clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] ins_o;
   logic        ins_valid_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        stall_i;
   logic        is_jump_i;
   logic        is_jr_i;
   logic [25:0] j_addr_i;
   logic [31:0] jr_target_i;
   logic        is_branch_i;
   logic        branch_taken_i;
   logic [31:0] ext_immd_i;

   int tests;
   int failed;
   int ready_delay;
   int wait_cnt;

   typedef struct {
      logic        jump;
      logic        jr;
      logic [25:0] j_addr;
      logic [31:0] jr_tgt;
      logic        br;
      logic        taken;
      logic [31:0] immd;
      logic        redir;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   ifetch dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .ins_o(ins_o), .ins_valid_o(ins_valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
      .stall_i(stall_i), .is_jump_i(is_jump_i), .is_jr_i(is_jr_i), .j_addr_i(j_addr_i),
      .jr_target_i(jr_target_i), .is_branch_i(is_branch_i), .branch_taken_i(branch_taken_i),
      .ext_immd_i(ext_immd_i)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F96;
   endfunction

   // Memory model: ready after ready_delay wait cycles; data is garbage outside the ready cycle
   always @(posedge sys_clk) begin
      if (!imem_req || imem_ready) wait_cnt <= 0;
      else                         wait_cnt <= wait_cnt + 1;
   end
   assign imem_ready = imem_req && (wait_cnt == ready_delay);
   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      stall_i = 1'b0; is_jump_i = 1'b0; is_jr_i = 1'b0; j_addr_i = 26'h0;
      jr_target_i = 32'h0; is_branch_i = 1'b0; branch_taken_i = 1'b0; ext_immd_i = 32'h0;
   endtask

   // Leaves the bench at a falling edge with the DUT in its first FETCH cycle
   task automatic reset_dut();
      clear_inputs();
      ready_delay = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("rst_req",   {31'h0, imem_req}, 32'h0);
      check("rst_addr",  imem_addr, 32'h0000_0000);
      check("rst_ins",   ins_o, 32'h0);
      check("rst_valid", {31'h0, ins_valid_o}, 32'h0);
      check("rst_pc",    pc_o, 32'h0000_0000);
      check("rst_pc4",   pc_plus4_o, 32'h0000_0004);
      rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         if (ins_valid_o) break;
         @(negedge sys_clk);
      end
      check("valid_timeout", {31'h0, ins_valid_o}, 32'h1);
   endtask

   // Jump (via jr at RESET_PC) until the instruction at target is presented
   task automatic goto_pc(input logic [31:0] target);
      reset_dut();
      wait_valid();
      is_jr_i = 1'b1;
      jr_target_i = target;
      @(negedge sys_clk);
      clear_inputs();
      for (int i = 0; i < 20; i++) begin
         if (ins_valid_o && pc_o == target) break;
         @(negedge sys_clk);
      end
      check("goto_pc", pc_o, target);
      check("goto_valid", {31'h0, ins_valid_o}, 32'h1);
   endtask

   initial begin
      tests = 0; failed = 0; wait_cnt = 0;
      //           jump  jr    j_addr        jr_tgt          br    taken immd            redir exp
      vecs[0] = '{1'b1, 1'b0, 26'h0000100, 32'h0,          1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0400};
      vecs[1] = '{1'b0, 1'b0, 26'h0,       32'h0,          1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0040_0004};
      vecs[2] = '{1'b0, 1'b0, 26'h0,       32'h0,          1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0040_0014};
      vecs[3] = '{1'b0, 1'b1, 26'h0,       32'h1234_5677, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1234_5674};
      vecs[4] = '{1'b1, 1'b1, 26'h0000100, 32'h0000_000B, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0008};
      vecs[5] = '{1'b0, 1'b0, 26'h0,       32'h0,          1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0040_0014};
      vecs[6] = '{1'b1, 1'b0, 26'h0000100, 32'h0,          1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0400};
      vecs[7] = '{1'b0, 1'b0, 26'h0,       32'h0,          1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0040_0054};

      // Sequential zero-wait fetch
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         check("seq_req",   {31'h0, imem_req}, 32'h1);
         check("seq_addr",  imem_addr, 32'(4 * k));
         check("seq_valid0", {31'h0, ins_valid_o}, 32'h0);
         @(negedge sys_clk);
         check("seq_valid1", {31'h0, ins_valid_o}, 32'h1);
         check("seq_ins",   ins_o, mem_word(32'(4 * k)));
         check("seq_pc",    pc_o, 32'(4 * k));
         check("seq_pc4",   pc_plus4_o, 32'(4 * k + 4));
         check("seq_noreq", {31'h0, imem_req}, 32'h0);
         if (k < 3) @(negedge sys_clk);
      end

      // Three wait states on the fetch of address 16
      ready_delay = 3;
      for (int c = 0; c < 4; c++) begin
         @(negedge sys_clk);
         check("wait_req",  {31'h0, imem_req}, 32'h1);
         check("wait_addr", imem_addr, 32'h0000_0010);
         check("wait_ins",  ins_o, mem_word(32'h0000_000C));
         check("wait_rdy",  {31'h0, imem_ready}, (c == 3) ? 32'h1 : 32'h0);
      end
      @(negedge sys_clk);
      check("wait_valid", {31'h0, ins_valid_o}, 32'h1);
      check("wait_cap",   ins_o, mem_word(32'h0000_0010));

      // Five stalled VALID cycles
      ready_delay = 0;
      stall_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk);
         check("stall_valid", {31'h0, ins_valid_o}, 32'h1);
         check("stall_ins",   ins_o, mem_word(32'h0000_0010));
         check("stall_pc",    pc_o, 32'h0000_0010);
         check("stall_req",   {31'h0, imem_req}, 32'h0);
      end
      stall_i = 1'b0;
      @(negedge sys_clk);
      check("resume_req",  {31'h0, imem_req}, 32'h1);
      check("resume_addr", imem_addr, 32'h0000_0014);

      // Redirect table at pc 0x0040_0010
      for (int v = 0; v < 8; v++) begin
         goto_pc(32'h0040_0010);
         is_jump_i = vecs[v].jump;  is_jr_i = vecs[v].jr;  j_addr_i = vecs[v].j_addr;
         jr_target_i = vecs[v].jr_tgt;  is_branch_i = vecs[v].br;
         branch_taken_i = vecs[v].taken;  ext_immd_i = vecs[v].immd;
         @(negedge sys_clk);
         clear_inputs();
`ifdef IFETCH_DELAY_SLOT_EN
         check($sformatf("slot_addr%0d", v), imem_addr, 32'h0040_0014);
         wait_valid();
         // Slot carries its own taken branch, which must be ignored
         is_branch_i = 1'b1; branch_taken_i = 1'b1; ext_immd_i = 32'h0000_0100;
         @(negedge sys_clk);
         clear_inputs();
         check($sformatf("redir_addr%0d", v), imem_addr, vecs[v].redir ? vecs[v].exp : 32'h0040_0018);
`else
         check($sformatf("redir_req%0d", v), {31'h0, imem_req}, 32'h1);
         check($sformatf("redir_addr%0d", v), imem_addr, vecs[v].exp);
`endif
      end

      // PC wrap from the top of the address space
      goto_pc(32'hFFFF_FFFC);
      check("wrap_pc4", pc_plus4_o, 32'h0000_0000);
      @(negedge sys_clk);
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Async reset while waiting on imem_ready
      reset_dut();
      ready_delay = 5;
      @(negedge sys_clk);
      check("ar_req_before", {31'h0, imem_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_req_drop", {31'h0, imem_req}, 32'h0);
      check("ar_valid",    {31'h0, ins_valid_o}, 32'h0);
      ready_delay = 0;
      @(negedge sys_clk);
      rst_n = 1'b1;
      @(negedge sys_clk);
      check("ar_restart_req",  {31'h0, imem_req}, 32'h1);
      check("ar_restart_addr", imem_addr, 32'h0000_0000);
      check("ar_restart_vld",  {31'h0, ins_valid_o}, 32'h0);
      @(negedge sys_clk);
      check("ar_first_ins", ins_o, mem_word(32'h0000_0000));
      check("ar_first_vld", {31'h0, ins_valid_o}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: owns the program counter and issues one instruction-memory request at a time. It presents each fetched word to the instruction decoder as `ins_o`, with a valid/stall handshake. It computes the next PC from the decoder's control-transfer outputs (jump, jr/jalr, branch with extended immediate) and the externally resolved branch condition. It is the producer end of the decoder's `ins_i` path.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
- sys_clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held high with `imem_addr` stable until `imem_ready`.
- imem_addr  out  32  word-aligned fetch address; always equals the current PC.
- imem_rdata  in  32  instruction word; valid only in a cycle where `imem_ready`=1.
- imem_ready  in  1  memory completes the outstanding request this cycle.
- ins_o  out  32  fetched instruction to decoder.
- ins_valid_o  out  1  `ins_o`/`pc_o` hold a valid instruction.
- pc_o  out  32  address of `ins_o`.
- pc_plus4_o  out  32  `pc_o` + 4, modulo 2^32.
- stall_i  in  1  downstream hold; instruction accepted when `ins_valid_o` && !`stall_i`.
- is_jump_i  in  1  decoder: j/jal, or jr/jalr.
- is_jr_i  in  1  decoder: jr/jalr (register target).
- j_addr_i  in  26  decoder: J-type target field.
- jr_target_i  in  32  decoder: rs register value.
- is_branch_i  in  1  decoder: beq/bne/blez/bgtz.
- branch_taken_i  in  1  resolved branch condition for the presented instruction.
- ext_immd_i  in  32  decoder: sign-extended offset.

## Operation
- States: BOOT, FETCH, VALID.
  - BOOT: reset state. `imem_req`=0. Moves to FETCH unconditionally on the first edge after `rst_n` rises.
  - FETCH: `imem_req`=1, `imem_addr`=pc. If `imem_ready`: capture `imem_rdata` into `ins_o`, set `pc_o`=pc, go to VALID. Otherwise stay in FETCH.
  - VALID: `ins_valid_o`=1, `imem_req`=0. While `stall_i`=1, `ins_o`, `pc_o` and `ins_valid_o` hold. On accept: pc <= next PC, go to FETCH.
- Redirect inputs are sampled only in the accept cycle and describe the instruction on `ins_o`.
- Target priority:
  - 1. `is_jr_i`: {`jr_target_i`[31:2], 2'b00}; low bits are silently forced to zero.
  - 2. `is_jump_i`: {`pc_plus4_o`[31:28], `j_addr_i`, 2'b00}.
  - 3. `is_branch_i` && `branch_taken_i`: `pc_plus4_o` + (`ext_immd_i` << 2), modulo 2^32.
  - Otherwise: `pc_plus4_o`.
- `branch_taken_i` is ignored when `is_branch_i`=0.
- PC arithmetic wraps: PC 32'hFFFF_FFFC sequentially fetches 32'h0000_0000.
- Exactly one request is outstanding. The request is never withdrawn before `imem_ready`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `ins_o`=0, `ins_valid_o`=0, `pc_o`=RESET_PC, `pc_plus4_o`=RESET_PC+4. Internal pending-target state is cleared.
- Reset asserted mid-request: `imem_req` drops asynchronously. The memory side must discard the transaction.
- First request is issued in the cycle after reset release.
- Fetch latency: `ins_valid_o` rises the cycle after the `imem_ready` cycle. With zero-wait memory (`imem_ready` high in the request's first cycle), peak throughput is one instruction per 2 cycles.
- The accept cycle and the next FETCH cycle are adjacent. The new `imem_addr` appears the cycle after accept.
- `stall_i` has no effect outside VALID.

## Configuration
- `IFETCH_DELAY_SLOT_EN` defined (MIPS delay slot):
  - On accept of a redirecting instruction, the target is stored in a pending register and the next fetch is `pc_plus4_o`.
  - When that delay-slot instruction is accepted, next PC is the pending target, regardless of the slot's own redirect inputs. The pending register then clears.
- Not defined: the redirect target is fetched immediately; the sequential instruction is never fetched.
- Reset clears the pending target in both builds.

## Test plan
- Reset, RESET_PC=32'h0000_0000, zero-wait memory, no stalls, no redirects:
  - `imem_addr` is 0, 4, 8, 12 on successive FETCH cycles.
  - `ins_valid_o` toggles 0,1,0,1.
  - `ins_o` matches memory at each `pc_o`.
- `imem_ready` delayed 3 cycles:
  - `imem_req` held 4 cycles with constant `imem_addr`.
  - `ins_o` captured only in the ready cycle.
- `stall_i`=1 for 5 cycles in VALID:
  - `ins_o`/`pc_o` unchanged, no new request.
  - Fetch resumes the cycle after `stall_i` falls.
- Redirects at `pc_o`=32'h0040_0010:
  - `is_jump_i` with `j_addr_i`=26'h0000100 -> next `imem_addr`=32'h0000_0400.
  - Branch taken with `ext_immd_i`=32'hFFFF_FFFC -> 32'h0040_0004.
  - Branch not taken -> 32'h0040_0014.
  - `is_jr_i` with `jr_target_i`=32'h1234_5677 -> 32'h1234_5674.
- Same jump with `IFETCH_DELAY_SLOT_EN`:
  - Fetch order 32'h0040_0010, 32'h0040_0014, 32'h0000_0400.
  - A taken branch in the slot is ignored.
- Async reset pulse while FETCH is waiting on `imem_ready`:
  - `imem_req` drops immediately.
  - After release, fetch restarts at RESET_PC with no stale `ins_valid_o`.
